// File: rtl/iq_accumulator_pkg.sv
// Shared definitions for the IQ processing chain: accumulator states and default widths.
package iq_accumulator_pkg;

  localparam int DEFAULT_SAMPLE_WIDTH   = 12;
  localparam int DEFAULT_ACC_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } accState_t;

endpackage

// File: rtl/iq_accumulator_sat_add.sv
// Signed adder that clamps to the representable range and flags when it did.
module sat_add #(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] sum,
  output logic                    sat
);

  logic signed [WIDTH:0] full;

  // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
  always_comb begin
    full = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    // The extra top bit disagreeing with the sign bit means the true sum left the range.
    sat  = full[WIDTH] ^ full[WIDTH-1];
    if (!sat)
      sum = full[WIDTH-1:0];
    else if (full[WIDTH])
      sum = {1'b1, {(WIDTH-1){1'b0}}};
    else
      sum = {1'b0, {(WIDTH-1){1'b1}}};
  end

endmodule

// File: rtl/iq_accumulator.sv
// Integrate-and-dump of I/Q samples over ACC_LEN valid samples with saturating sums
// and an optional partial-frame dump when enable drops.
module iq_accumulator
  import iq_accumulator_pkg::*;
#(
  parameter int SAMPLE_WIDTH   = DEFAULT_SAMPLE_WIDTH,
  parameter int ACC_DATA_WIDTH = DEFAULT_ACC_DATA_WIDTH,
  parameter int ACC_LEN        = 32,
  parameter bit FLUSH_PARTIAL  = 1'b1
) (
  input  logic                             sampleClk,
  input  logic                             resetN,
  input  logic                             enable,
  input  logic                             sampleValid,
  input  logic signed [SAMPLE_WIDTH-1:0]   sampleI,
  input  logic signed [SAMPLE_WIDTH-1:0]   sampleQ,
  output logic                             accumulatorValid,
  output logic signed [ACC_DATA_WIDTH-1:0] accumulatorData_I,
  output logic signed [ACC_DATA_WIDTH-1:0] accumulatorData_Q,
  output logic                             accumulatorSat,
  output logic                             accumulatorPartial
);

  localparam int CNT_W = $clog2(ACC_LEN + 1);

  accState_t state, stateNext;

  logic signed [ACC_DATA_WIDTH-1:0] sumI, sumQ, nextSumI, nextSumQ, extI, extQ;
  logic                             satI, satQ, sticky;
  logic [CNT_W-1:0]                 count;
  logic                             running, accept, lastSample, flushDump;

  assign extI = ACC_DATA_WIDTH'(sampleI);
  assign extQ = ACC_DATA_WIDTH'(sampleQ);

  sat_add #(.WIDTH(ACC_DATA_WIDTH)) addI (.a(sumI), .b(extI), .sum(nextSumI), .sat(satI));
  sat_add #(.WIDTH(ACC_DATA_WIDTH)) addQ (.a(sumQ), .b(extQ), .sum(nextSumQ), .sat(satQ));

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (enable)  stateNext = RUN;
      RUN:     if (!enable) stateNext = FLUSH;
      FLUSH:   stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // A sample on the edge where enable falls is dropped: accept requires enable still high.
  assign running    = (state == RUN) && enable;
  assign accept     = running && sampleValid;
  assign lastSample = accept && (count == CNT_W'(ACC_LEN - 1));
  assign flushDump  = (state == RUN) && !enable && (count != '0) && FLUSH_PARTIAL;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge sampleClk) begin
    if (!resetN) begin
      state              <= IDLE;
      count              <= '0;
      sumI               <= '0;
      sumQ               <= '0;
      sticky             <= 1'b0;
      accumulatorValid   <= 1'b0;
      accumulatorData_I  <= '0;
      accumulatorData_Q  <= '0;
      accumulatorSat     <= 1'b0;
      accumulatorPartial <= 1'b0;
    end else begin
      state            <= stateNext;
      accumulatorValid <= 1'b0;
      if (running) begin
        if (lastSample) begin
          accumulatorValid   <= 1'b1;
          accumulatorData_I  <= nextSumI;
          accumulatorData_Q  <= nextSumQ;
          accumulatorSat     <= sticky | satI | satQ;
          accumulatorPartial <= 1'b0;
          count              <= '0;
          sumI               <= '0;
          sumQ               <= '0;
          sticky             <= 1'b0;
        end else if (accept) begin
          count  <= count + 1'b1;
          sumI   <= nextSumI;
          sumQ   <= nextSumQ;
          sticky <= sticky | satI | satQ;
        end
      end else begin
        if (flushDump) begin
          accumulatorValid   <= 1'b1;
          accumulatorData_I  <= sumI;
          accumulatorData_Q  <= sumQ;
          accumulatorSat     <= sticky;
          accumulatorPartial <= 1'b1;
        end
        count  <= '0;
        sumI   <= '0;
        sumQ   <= '0;
        sticky <= 1'b0;
      end
    end
  end

endmodule
